calc_regfile_alu: RTL and testbench

//  Parametrised successor to the 4x4-bit register calculator: NREGS signed WIDTH-bit registers, 8-op ALU.
//  Per accepted op: rd = r[src] OP imm, written to r[dst]. Adds a valid/ready handshake and an optional saturating ADD/SUB.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/calc_mul_iter.sv | 47 ++++
 rtl/calc_regfile_alu.sv | 133 +++++++++++++
 tb/tb_calc_regfile_alu.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared opcodes and FSM encoding
// for the register-file calculator core.
package calc_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_ANDN = 3'b100;
  localparam logic [2:0] OP_ORN  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/calc_mul_iter.sv
// Iterative signed multiplier: one partial
// product per cycle, sign bit subtracted last.
module calc_mul_iter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] pp;

  assign pp   = b_q[cnt] ? ({{WIDTH{a_q[WIDTH-1]}}, a_q} << cnt) : '0;
  assign done = busy && (cnt == CW'(WIDTH - 1));

  // Latch operands on start, then accumulate one bit per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      product <= '0;
    end else if (start) begin
      a_q     <= a;
      b_q     <= b;
      cnt     <= '0;
      busy    <= 1'b1;
      product <= '0;
    end else if (busy) begin
      product <= done ? product - pp : product + pp;
      cnt     <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_regfile_alu.sv
// Register-file calculator: r[dst] = r[src] OP imm,
// with valid/ready intake and an iterative MUL.
module calc_regfile_alu
  import calc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREGS = 4,
  parameter int SAT   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               control,
  input  logic [$clog2(NREGS)-1:0] src_addr,
  input  logic [$clog2(NREGS)-1:0] dst_addr,
  input  logic [WIDTH-1:0]         immediate,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_ovf,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [WIDTH-1:0]         dbg_data
);

  localparam int AW = $clog2(NREGS);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state;
  logic [WIDTH-1:0]   regs [NREGS];
  logic [AW-1:0]      mul_dst;
  logic [WIDTH:0]     alu_q;
  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_p;
  logic [WIDTH:0]     mul_hi;
  logic               mul_ovf;

  // Returns {ovf, result} for every single-cycle op
  function automatic logic [WIDTH:0] alu(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] r;
    logic             v;
    s = '0;
    r = '0;
    v = 1'b0;
    unique case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ANDN: r = a & ~b;
      OP_ORN:  r = a | ~b;
      OP_ADD, OP_SUB: begin
        if (op == OP_ADD)
          s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        else
          s = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        v = s[WIDTH] ^ s[WIDTH-1];
        r = s[WIDTH-1:0];
        if (SAT != 0 && v)
          r = s[WIDTH] ? SMIN : SMAX;
      end
      OP_SLT:
        r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      default: r = '0;
    endcase
    return {v, r};
  endfunction

  assign in_ready  = (state == IDLE) && !mul_busy;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (control == OP_MUL);
  assign alu_q     = alu(control, regs[src_addr], immediate);
  assign dbg_data  = regs[dbg_addr];
  assign mul_hi    = mul_p[2*WIDTH-1:WIDTH-1];
  assign mul_ovf   = !((&mul_hi) || !(|mul_hi));

  calc_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (regs[src_addr]),
    .b       (immediate),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_p)
  );

  // Control FSM, register file writes and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mul_dst   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mul_start) begin
            mul_dst <= dst_addr;
            state   <= MUL;
          end else if (accept) begin
            regs[dst_addr] <= alu_q[WIDTH-1:0];
            out_data       <= alu_q[WIDTH-1:0];
            out_ovf        <= alu_q[WIDTH];
            out_valid      <= 1'b1;
          end
        end
        MUL: begin
          if (mul_done) state <= DONE;
        end
        DONE: begin
          regs[mul_dst] <= mul_p[WIDTH-1:0];
          out_data      <= mul_p[WIDTH-1:0];
          out_ovf       <= mul_ovf;
          out_valid     <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_regfile_alu.sv
// Directed bench for calc_regfile_alu; a SAT=1
// twin shares stimulus for the saturation cases.
module tb_calc_regfile_alu;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] control = 3'd0;
  logic [1:0] src_addr = 2'd0;
  logic [1:0] dst_addr = 2'd0;
  logic [3:0] immediate = 4'd0;
  logic [1:0] dbg_addr = 2'd0;

  logic       in_ready, out_valid, out_ovf;
  logic [3:0] out_data, dbg_data;
  logic       s_in_ready, s_out_valid, s_out_ovf;
  logic [3:0] s_out_data, s_dbg_data;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  calc_regfile_alu #(.WIDTH(4), .NREGS(4), .SAT(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .control(control), .src_addr(src_addr), .dst_addr(dst_addr),
    .immediate(immediate), .out_valid(out_valid), .out_data(out_data),
    .out_ovf(out_ovf), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  calc_regfile_alu #(.WIDTH(4), .NREGS(4), .SAT(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .control(control), .src_addr(src_addr), .dst_addr(dst_addr),
    .immediate(immediate), .out_valid(s_out_valid), .out_data(s_out_data),
    .out_ovf(s_out_ovf), .dbg_addr(dbg_addr), .dbg_data(s_dbg_data)
  );

  // Present one op at negedge, accept at posedge, sample 1 time unit later
  task automatic issue(input logic [2:0] c, input logic [1:0] s,
                       input logic [1:0] d, input logic [3:0] imm);
    @(negedge clk);
    in_valid = 1'b1; control = c; src_addr = s; dst_addr = d; immediate = imm;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready got %b want 1", in_ready); n_fail++;
    end
    n_checks++;
    if ({out_valid, out_ovf, out_data} !== 6'b0) begin
      $display("FAIL reset_outputs got v=%b o=%b d=%h want 0", out_valid, out_ovf, out_data);
      n_fail++;
    end
    n_checks++;
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i); #1;
      if (dbg_data !== 4'h0) begin
        $display("FAIL reset_r%0d got %h want 0", i, dbg_data); n_fail++;
      end
      n_checks++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [3:0] exp [4];
    exp[0] = 4'h2; exp[1] = 4'h4; exp[2] = 4'h0; exp[3] = 4'h1;
    for (int i = 0; i < 4; i++) begin
      unique case (i)
        0: issue(3'b010, 2'd0, 2'd0, 4'h2);
        1: issue(3'b110, 2'd0, 2'd1, 4'hE);
        2: issue(3'b000, 2'd1, 2'd2, 4'h1);
        default: issue(3'b111, 2'd1, 2'd3, 4'h7);
      endcase
      if (out_valid !== 1'b1 || out_data !== exp[i] || out_ovf !== 1'b0) begin
        $display("FAIL basic_op%0d got v=%b d=%h o=%b want v=1 d=%h o=0",
                 i, out_valid, out_data, out_ovf, exp[i]);
        n_fail++;
      end
      n_checks++;
    end
    dbg_addr = 2'd1; #1;
    if (dbg_data !== 4'h4) begin
      $display("FAIL basic_dbg_r1 got %h want 4", dbg_data); n_fail++;
    end
    n_checks++;
    dbg_addr = 2'd3; #1;
    if (dbg_data !== 4'h1) begin
      $display("FAIL basic_dbg_r3 got %h want 1", dbg_data); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_negative();
    issue(3'b010, 2'd1, 2'd2, 4'h8);
    if (out_data !== 4'hC || out_ovf !== 1'b0) begin
      $display("FAIL neg_add got d=%h o=%b want d=c o=0", out_data, out_ovf); n_fail++;
    end
    n_checks++;
    issue(3'b110, 2'd2, 2'd2, 4'h4);
    if (out_data !== 4'h8 || out_ovf !== 1'b0) begin
      $display("FAIL neg_sub got d=%h o=%b want d=8 o=0", out_data, out_ovf); n_fail++;
    end
    n_checks++;
    issue(3'b111, 2'd2, 2'd0, 4'h7);
    if (out_data !== 4'h1) begin
      $display("FAIL neg_slt got %h want 1", out_data); n_fail++;
    end
    n_checks++;
    issue(3'b100, 2'd1, 2'd3, 4'hC);
    if (out_data !== 4'h0) begin
      $display("FAIL andn got %h want 0", out_data); n_fail++;
    end
    n_checks++;
    issue(3'b101, 2'd1, 2'd3, 4'hE);
    if (out_data !== 4'h5) begin
      $display("FAIL orn got %h want 5", out_data); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_valid = 1'b1; control = 3'b010; src_addr = 2'd1; dst_addr = 2'd3; immediate = 4'h1;
    @(posedge clk); #1;
    if (out_valid !== 1'b1 || out_data !== 4'h5) begin
      $display("FAIL b2b_first got v=%b d=%h want v=1 d=5", out_valid, out_data); n_fail++;
    end
    n_checks++;
    src_addr = 2'd3; dst_addr = 2'd0;
    @(posedge clk); #1;
    if (out_valid !== 1'b1 || out_data !== 4'h6) begin
      $display("FAIL b2b_dep got v=%b d=%h want v=1 d=6", out_valid, out_data); n_fail++;
    end
    n_checks++;
    src_addr = 2'd1; dst_addr = 2'd1; control = 3'b110; immediate = 4'hF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (out_valid !== 1'b1 || out_data !== 4'h5) begin
      $display("FAIL b2b_src_eq_dst got v=%b d=%h want v=1 d=5", out_valid, out_data); n_fail++;
    end
    n_checks++;
    @(posedge clk); #1;
    if (out_valid !== 1'b0) begin
      $display("FAIL b2b_pulse got %b want 0", out_valid); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_overflow();
    do_reset();
    issue(3'b010, 2'd0, 2'd0, 4'h7);
    issue(3'b010, 2'd0, 2'd0, 4'h1);
    if (out_data !== 4'h8 || out_ovf !== 1'b1) begin
      $display("FAIL ovf_add_wrap got d=%h o=%b want d=8 o=1", out_data, out_ovf); n_fail++;
    end
    n_checks++;
    if (s_out_data !== 4'h7 || s_out_ovf !== 1'b1) begin
      $display("FAIL ovf_add_sat got d=%h o=%b want d=7 o=1", s_out_data, s_out_ovf); n_fail++;
    end
    n_checks++;
    do_reset();
    issue(3'b010, 2'd1, 2'd1, 4'h8);
    issue(3'b110, 2'd1, 2'd1, 4'h1);
    if (out_data !== 4'h7 || out_ovf !== 1'b1) begin
      $display("FAIL ovf_sub_wrap got d=%h o=%b want d=7 o=1", out_data, out_ovf); n_fail++;
    end
    n_checks++;
    if (s_out_data !== 4'h8 || s_out_ovf !== 1'b1) begin
      $display("FAIL ovf_sub_sat got d=%h o=%b want d=8 o=1", s_out_data, s_out_ovf); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_mul();
    int lows;
    int pulses;
    logic [3:0] exp_d [2];
    logic [3:0] imm_v [2];
    logic       exp_o [2];
    exp_d[0] = 4'hA; imm_v[0] = 4'hE; exp_o[0] = 1'b0;
    exp_d[1] = 4'hC; imm_v[1] = 4'h4; exp_o[1] = 1'b1;
    do_reset();
    issue(3'b010, 2'd0, 2'd0, 4'h3);
    for (int k = 0; k < 2; k++) begin
      issue(3'b011, 2'd0, 2'(k + 1), imm_v[k]);
      lows = 0;
      pulses = 0;
      while (in_ready === 1'b0 && lows < 20) begin
        lows++;
        if (out_valid === 1'b1) pulses++;
        @(posedge clk); #1;
      end
      if (out_valid === 1'b1) pulses++;
      if (lows != 5) begin
        $display("FAIL mul%0d_busy_cycles got %0d want 5", k, lows); n_fail++;
      end
      n_checks++;
      if (out_data !== exp_d[k] || out_ovf !== exp_o[k]) begin
        $display("FAIL mul%0d_result got d=%h o=%b want d=%h o=%b",
                 k, out_data, out_ovf, exp_d[k], exp_o[k]);
        n_fail++;
      end
      n_checks++;
      @(posedge clk); #1;
      if (out_valid === 1'b1) pulses++;
      if (pulses != 1) begin
        $display("FAIL mul%0d_pulses got %0d want 1", k, pulses); n_fail++;
      end
      n_checks++;
      dbg_addr = 2'(k + 1); #1;
      if (dbg_data !== exp_d[k]) begin
        $display("FAIL mul%0d_dbg got %h want %h", k, dbg_data, exp_d[k]); n_fail++;
      end
      n_checks++;
    end
  endtask

  task automatic test_hold_during_mul();
    int pulses;
    logic rp;
    issue(3'b011, 2'd0, 2'd3, 4'h2);
    in_valid = 1'b1; control = 3'b010; src_addr = 2'd2; dst_addr = 2'd2; immediate = 4'h1;
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      rp = in_ready;
      @(posedge clk); #1;
      if (out_valid === 1'b1) pulses++;
      if (rp) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    if (pulses != 2) begin
      $display("FAIL hold_pulses got %0d want 2", pulses); n_fail++;
    end
    n_checks++;
    dbg_addr = 2'd2; #1;
    if (dbg_data !== 4'hD) begin
      $display("FAIL hold_once got %h want d", dbg_data); n_fail++;
    end
    n_checks++;
    dbg_addr = 2'd3; #1;
    if (dbg_data !== 4'h6) begin
      $display("FAIL hold_mul got %h want 6", dbg_data); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_reset_mid_mul();
    int pulses;
    issue(3'b011, 2'd0, 2'd1, 4'h3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL midrst_ready got r=%b v=%b want r=1 v=0", in_ready, out_valid); n_fail++;
    end
    n_checks++;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) pulses++;
    end
    if (pulses != 0 || in_ready !== 1'b1) begin
      $display("FAIL midrst_no_write got pulses=%0d r=%b want 0 and 1", pulses, in_ready);
      n_fail++;
    end
    n_checks++;
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i); #1;
      if (dbg_data !== 4'h0) begin
        $display("FAIL midrst_r%0d got %h want 0", i, dbg_data); n_fail++;
      end
      n_checks++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_back_to_back();
    test_overflow();
    test_mul();
    test_hold_during_mul();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
